// File: rtl/light_safety_driver.sv
// light_safety_driver
//   Drives per-direction R/Y/G lamp pads from the sequencer's 2-bit lamp codes
//   and independently monitors them for conflicts. A persistent conflict latches
//   a fault and forces flashing red until an operator clear, followed by a
//   steady all-red recovery period.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   north      in   2  lamp code: 00 red, 01 yellow, 10 green, 11 illegal
//   east       in   2  lamp code
//   south      in   2  lamp code
//   west       in   2  lamp code
//   fault_clr  in   1  single-cycle operator clear request
//   lamp_r     out  4  red lamps    [3]=N [2]=E [1]=S [0]=W
//   lamp_y     out  4  yellow lamps, same order
//   lamp_g     out  4  green lamps, same order
//   fault      out  1  high while in FAULT
//   fault_cnt  out  4  fault entries, saturating at 15
//
// State   | meaning
// --------+-------------------------------------------------------------
// NORMAL  | lamps follow the sampled codes
// FAULT   | conflict latched, all lamps flash red, waiting for fault_clr
// RECOVER | steady all-red until RECOVER_CYC clean cycles have elapsed

module light_safety_driver #(
  parameter int BLINK_DIV    = 25_000_000,
  parameter int CONFLICT_CYC = 2,
  parameter int RECOVER_CYC  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] north,
  input  logic [1:0] east,
  input  logic [1:0] south,
  input  logic [1:0] west,
  input  logic       fault_clr,
  output logic [3:0] lamp_r,
  output logic [3:0] lamp_y,
  output logic [3:0] lamp_g,
  output logic       fault,
  output logic [3:0] fault_cnt
);

  localparam int BW = $clog2(BLINK_DIV) + 1;
  localparam int CW = $clog2(CONFLICT_CYC) + 1;
  localparam int RW = $clog2(RECOVER_CYC) + 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CF_LAST    = CW'(CONFLICT_CYC - 1);
  localparam logic [CW-1:0] CF_MAX     = CW'(CONFLICT_CYC);
  localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYC - 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0][1:0] r_code;      // [3]=N [2]=E [1]=S [0]=W
  logic [CW-1:0]   r_cf_cnt;
  logic [CW-1:0]   w_cf_nxt;
  logic [RW-1:0]   r_rec_cnt;
  logic [RW-1:0]   w_rec_nxt;
  logic [BW-1:0]   r_blk_cnt;
  logic [BW-1:0]   w_blk_nxt;
  logic            r_phase;
  logic            w_phase_nxt;
  logic            w_enter_fault;
  logic [3:0]      w_nonred;
  logic [3:0]      w_green;
  logic [3:0]      w_ill;
  logic            w_conflict;
  logic            w_cf_hit;
  logic [3:0]      w_dec_r;
  logic [3:0]      w_dec_y;
  logic [3:0]      w_dec_g;
  logic [3:0]      w_r_nxt;
  logic [3:0]      w_y_nxt;
  logic [3:0]      w_g_nxt;

  // Conflict detection and decode, both on the sampled codes.
  // Code 11 decodes to red so a direction is never dark.
  always_comb begin
    w_conflict = 1'b0;
    w_dec_r    = 4'h0;
    w_dec_y    = 4'h0;
    w_dec_g    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      w_nonred[i] = (r_code[i] != 2'b00);
      w_green[i]  = (r_code[i] == 2'b10);
      w_ill[i]    = (r_code[i] == 2'b11);
      case (r_code[i])
        2'b01:   w_dec_y[i] = 1'b1;
        2'b10:   w_dec_g[i] = 1'b1;
        default: w_dec_r[i] = 1'b1;
      endcase
    end
    if (w_ill != 4'h0) w_conflict = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_green[i] && ((w_nonred & ~(4'b0001 << i)) != 4'h0)) w_conflict = 1'b1;
    end
  end

  // Hit when this cycle would be the CONFLICT_CYC-th consecutive conflict.
  assign w_cf_hit = w_conflict && (r_cf_cnt >= CF_LAST);

  always_comb begin
    w_cf_nxt = '0;
    if (w_conflict) w_cf_nxt = (r_cf_cnt < CF_MAX) ? r_cf_cnt + 1'b1 : r_cf_cnt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rec_nxt     = r_rec_cnt;
    w_blk_nxt     = r_blk_cnt;
    w_phase_nxt   = r_phase;
    w_enter_fault = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_cf_hit) w_enter_fault = 1'b1;
      end
      ST_RECOVER: begin
        if (w_cf_hit) begin
          w_enter_fault = 1'b1;
        end else if (w_conflict) begin
          w_rec_nxt = '0;
        end else if (r_rec_cnt == REC_LAST) begin
          w_state_nxt = ST_NORMAL;
          w_rec_nxt   = '0;
        end else begin
          w_rec_nxt = r_rec_cnt + 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !w_conflict) begin
          w_state_nxt = ST_RECOVER;
          w_rec_nxt   = '0;
        end else if (r_blk_cnt == BLINK_LAST) begin
          w_blk_nxt   = '0;
          w_phase_nxt = ~r_phase;
        end else begin
          w_blk_nxt = r_blk_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_RECOVER;
    endcase
    if (w_enter_fault) begin
      w_state_nxt = ST_FAULT;
      w_blk_nxt   = '0;
      w_phase_nxt = 1'b1;
    end
  end

  // Lamp outputs are registered from the next state so they change on the
  // same edge as the state register.
  always_comb begin
    w_r_nxt = 4'hF;
    w_y_nxt = 4'h0;
    w_g_nxt = 4'h0;
    case (w_state_nxt)
      ST_NORMAL: begin
        w_r_nxt = w_dec_r;
        w_y_nxt = w_dec_y;
        w_g_nxt = w_dec_g;
      end
      ST_FAULT: w_r_nxt = {4{w_phase_nxt}};
      default:  w_r_nxt = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RECOVER;
      r_code    <= '0;
      r_cf_cnt  <= '0;
      r_rec_cnt <= '0;
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
      lamp_r    <= 4'hF;
      lamp_y    <= 4'h0;
      lamp_g    <= 4'h0;
      fault     <= 1'b0;
      fault_cnt <= 4'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= {north, east, south, west};
      r_cf_cnt  <= w_cf_nxt;
      r_rec_cnt <= w_rec_nxt;
      r_blk_cnt <= w_blk_nxt;
      r_phase   <= w_phase_nxt;
      lamp_r    <= w_r_nxt;
      lamp_y    <= w_y_nxt;
      lamp_g    <= w_g_nxt;
      fault     <= (w_state_nxt == ST_FAULT);
      if (w_enter_fault && (fault_cnt != 4'hF)) fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_light_safety_driver.sv
module tb_light_safety_driver;
  localparam int BLINK_DIV    = 4;
  localparam int CONFLICT_CYC = 2;
  localparam int RECOVER_CYC  = 3;

  localparam int M_NORMAL  = 0;
  localparam int M_FAULT   = 1;
  localparam int M_RECOVER = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] north = 2'b00, east = 2'b00, south = 2'b00, west = 2'b00;
  logic       fault_clr = 1'b0;
  logic [3:0] lamp_r, lamp_y, lamp_g, fault_cnt;
  logic       fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  light_safety_driver #(
    .BLINK_DIV   (BLINK_DIV),
    .CONFLICT_CYC(CONFLICT_CYC),
    .RECOVER_CYC (RECOVER_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .north    (north),
    .east     (east),
    .south    (south),
    .west     (west),
    .fault_clr(fault_clr),
    .lamp_r   (lamp_r),
    .lamp_y   (lamp_y),
    .lamp_g   (lamp_g),
    .fault    (fault),
    .fault_cnt(fault_cnt)
  );

  // Behavioural model: run lengths and ages rather than counters/encodings.
  int         m_mode, m_crun, m_quiet, m_age, m_cnt;
  int         m_smp [4];      // 0=N 1=E 2=S 3=W, codes seen by the DUT sampler
  logic [3:0] e_r, e_y, e_g, e_cnt;
  logic       e_fault;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RECOVER; m_crun = 0; m_quiet = 0; m_age = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_smp[i] = 0;
    e_r = 4'hF; e_y = 4'h0; e_g = 4'h0; e_fault = 1'b0; e_cnt = 4'h0;
  endtask

  task automatic model_step();
    int  ngreen, nlit;
    bit  ill, conf, enter;
    ngreen = 0; nlit = 0; ill = 0; enter = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_smp[i] == 3) ill = 1;
      if (m_smp[i] == 2) ngreen++;
      if (m_smp[i] != 0) nlit++;
    end
    conf   = ill || (ngreen > 0 && nlit > 1);
    m_crun = conf ? m_crun + 1 : 0;
    case (m_mode)
      M_NORMAL: if (m_crun >= CONFLICT_CYC) enter = 1;
      M_RECOVER: begin
        if (m_crun >= CONFLICT_CYC) enter = 1;
        else begin
          m_quiet = conf ? 0 : m_quiet + 1;
          if (m_quiet == RECOVER_CYC) m_mode = M_NORMAL;
        end
      end
      default: begin
        if (fault_clr && !conf) begin
          m_mode = M_RECOVER; m_quiet = 0;
        end else m_age++;
      end
    endcase
    if (enter) begin
      m_mode = M_FAULT; m_age = 0;
      if (m_cnt < 15) m_cnt++;
    end
    e_r = 4'hF; e_y = 4'h0; e_g = 4'h0;
    if (m_mode == M_NORMAL) begin
      for (int i = 0; i < 4; i++) begin
        e_r[3-i] = (m_smp[i] == 0 || m_smp[i] == 3);
        e_y[3-i] = (m_smp[i] == 1);
        e_g[3-i] = (m_smp[i] == 2);
      end
    end else if (m_mode == M_FAULT) begin
      e_r = (((m_age / BLINK_DIV) % 2) == 0) ? 4'hF : 4'h0;
    end
    e_fault = (m_mode == M_FAULT);
    e_cnt   = 4'(m_cnt);
    m_smp[0] = int'(north); m_smp[1] = int'(east);
    m_smp[2] = int'(south); m_smp[3] = int'(west);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model_lamp_r", int'(lamp_r), int'(e_r));
        chk("model_lamp_y", int'(lamp_y), int'(e_y));
        chk("model_lamp_g", int'(lamp_g), int'(e_g));
        chk("model_fault", int'(fault), int'(e_fault));
        chk("model_fault_cnt", int'(fault_cnt), int'(e_cnt));
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set(input logic [1:0] n, e, s, w, input logic clr);
    north = n; east = e; south = s; west = w; fault_clr = clr;
  endtask

  task automatic rand_codes();
    int         r;
    logic [1:0] c [4];
    r = $urandom_range(0, 9);
    for (int i = 0; i < 4; i++) c[i] = 2'b00;
    if (r < 5) c[$urandom_range(0, 3)] = 2'($urandom_range(0, 2));
    else if (r < 7) for (int i = 0; i < 4; i++) c[i] = 2'($urandom_range(0, 1));
    else for (int i = 0; i < 4; i++) c[i] = 2'($urandom_range(0, 3));
    north = c[0]; east = c[1]; south = c[2]; west = c[3];
  endtask

  initial begin
    set(0, 0, 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    // 1: reset release, all-red during recovery, then NORMAL
    cyc(1);
    chk("reset_all_red", int'(lamp_r), 'hF);
    cyc(4);
    set(2, 0, 0, 0, 0);
    cyc(2);
    chk("n_green_g", int'(lamp_g), 'b1000);
    chk("n_green_r", int'(lamp_r), 'b0111);
    // 2: two yellows, legal
    set(1, 1, 0, 0, 0);
    cyc(2);
    chk("ne_yellow", int'(lamp_y), 'b1100);
    chk("ne_yellow_fault", int'(fault), 0);
    // 3: one-cycle conflict filtered, two-cycle conflict latches
    set(2, 2, 0, 0, 0);
    cyc(1);
    set(0, 0, 0, 0, 0);
    cyc(4);
    chk("short_conflict", int'(fault), 0);
    set(2, 2, 0, 0, 0);
    cyc(2);
    set(0, 0, 0, 0, 0);
    cyc(1);
    chk("fault_set", int'(fault), 1);
    chk("fault_cnt_1", int'(fault_cnt), 1);
    chk("fault_red", int'(lamp_r), 'hF);
    chk("fault_yg", int'({lamp_y, lamp_g}), 0);
    // 4: blinking and clear handling
    cyc(4);
    chk("blink_off", int'(lamp_r), 0);
    cyc(4);
    chk("blink_on", int'(lamp_r), 'hF);
    set(0, 0, 0, 3, 0);
    cyc(1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cyc(1);
    chk("clr_ignored", int'(fault), 1);
    set(1, 0, 0, 0, 0);
    cyc(1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("clr_to_recover", int'(fault), 0);
    chk("recover_red", int'(lamp_r), 'hF);
    cyc(2);
    chk("recover_hold", int'(lamp_y), 0);
    cyc(1);
    chk("normal_after_recover", int'(lamp_y), 'b1000);
    // 5: conflict inside recovery restarts the count
    set(2, 2, 0, 0, 0);
    cyc(2);
    set(1, 0, 0, 0, 0);
    cyc(2);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cyc(1);
    set(1, 0, 0, 3, 0);
    cyc(1);
    set(1, 0, 0, 0, 0);
    cyc(3);
    chk("recover_restart", int'(lamp_y), 0);
    cyc(1);
    chk("recover_restart_done", int'(lamp_y), 'b1000);
    for (int i = 0; i < 16; i++) begin
      set(2, 2, 0, 0, 0);
      cyc(2);
      set(0, 0, 0, 0, 0);
      cyc(2);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      cyc(4);
    end
    chk("cnt_saturate", int'(fault_cnt), 15);
    // randomized phase, checked by the compare process every cycle
    repeat (400) begin
      rand_codes();
      repeat ($urandom_range(1, 4)) begin
        fault_clr = ($urandom_range(0, 5) == 0);
        cyc(1);
      end
    end
    // 6: asynchronous reset in the middle of FAULT
    set(2, 2, 0, 0, 0);
    cyc(2);
    set(0, 0, 0, 0, 0);
    cyc(2);
    chk("pre_reset_fault", int'(fault), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_r", int'(lamp_r), 'hF);
    chk("async_rst_yg", int'({lamp_y, lamp_g}), 0);
    chk("async_rst_fault", int'(fault), 0);
    chk("async_rst_cnt", int'(fault_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set(0, 0, 2, 0, 0);
    cyc(6);
    chk("post_reset_s_green", int'(lamp_g), 'b0010);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
